// File: rtl/miriscv_prefetch_stage.sv
// In-order instruction prefetch stage for miriscv: bounded in-flight requests, instruction FIFO,
// and a fetch-to-decode output register. Redirects flush the FIFO and discard stale responses.
module miriscv_prefetch_stage #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned ILEN            = 32,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] boot_addr_i,
    output logic            instr_req_o,
    input  logic            instr_gnt_i,
    output logic [XLEN-1:0] instr_addr_o,
    input  logic            instr_rvalid_i,
    input  logic [XLEN-1:0] instr_rdata_i,
    input  logic [XLEN-1:0] cu_pc_bra_i,
    input  logic            cu_kill_f_i,
    input  logic            cu_boot_addr_load_en_i,
    input  logic            cu_stall_f_i,
    output logic [ILEN-1:0] f_instr_o,
    output logic [XLEN-1:0] f_current_pc_o,
    output logic [XLEN-1:0] f_next_pc_o,
    output logic            f_valid_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [ILEN-1:0] L_NOP = ILEN'(32'h0000_0013);

    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [ILEN-1:0] r_fifo_instr [DEPTH];
    logic [XLEN-1:0] r_fifo_pc    [DEPTH];
    logic [ILEN-1:0] r_f_instr;
    logic [XLEN-1:0] r_f_pc;
    logic [XLEN-1:0] r_f_next_pc;
    logic            r_f_valid;

    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic [CW-1:0]   w_live;
    logic [CW:0]     w_load;
    logic            w_req;
    logic            w_issue;
    logic            w_drop;
    logic            w_accept;
    logic            w_empty;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic [ILEN-1:0] w_rinstr;

    // Kill wins over boot load; both flush and suppress issue this cycle.
    assign w_redirect = cu_kill_f_i | cu_boot_addr_load_en_i;
    assign w_target   = cu_kill_f_i ? cu_pc_bra_i : boot_addr_i;

    // Live in-flight plus buffered entries bound the FIFO so a push never overflows.
    assign w_live  = r_outstanding - r_discard;
    assign w_load  = (CW+1)'(w_live) + (CW+1)'(r_count);
    assign w_req   = ~rst_i & ~w_redirect & (w_load < (CW+1)'(DEPTH))
                   & (r_outstanding < CW'(MAX_OUTSTANDING));
    assign w_issue = w_req & instr_gnt_i;

    assign w_rinstr = instr_rdata_i[ILEN-1:0];
    assign w_drop   = instr_rvalid_i & (r_discard != '0);
    assign w_accept = instr_rvalid_i & (r_discard == '0) & ~w_redirect & ~rst_i;
    assign w_empty  = (r_count == '0);
    assign w_bypass = w_accept & w_empty & ~cu_stall_f_i;
    assign w_push   = w_accept & ~w_bypass;
    assign w_pop    = ~rst_i & ~w_redirect & ~cu_stall_f_i & ~w_empty;

    assign instr_req_o    = w_req;
    assign instr_addr_o   = r_req_pc;
    assign f_instr_o      = r_f_instr;
    assign f_current_pc_o = r_f_pc;
    assign f_next_pc_o    = r_f_next_pc;
    assign f_valid_o      = r_f_valid;

    // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_instr[r_wptr] <= w_rinstr;
            r_fifo_pc[r_wptr]    <= r_resp_pc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req_pc      <= boot_addr_i;
            r_resp_pc     <= boot_addr_i;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_f_instr     <= L_NOP;
            r_f_pc        <= '0;
            r_f_next_pc   <= '0;
            r_f_valid     <= 1'b0;
        end else if (w_redirect) begin
            // Everything still in flight after this cycle's response is stale.
            r_req_pc      <= w_target;
            r_resp_pc     <= w_target;
            r_outstanding <= r_outstanding - CW'(instr_rvalid_i);
            r_discard     <= r_outstanding - CW'(instr_rvalid_i);
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_f_instr     <= L_NOP;
            r_f_pc        <= '0;
            r_f_next_pc   <= '0;
            r_f_valid     <= 1'b0;
        end else begin
            if (w_issue) begin
                r_req_pc <= r_req_pc + XLEN'(4);
            end
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(instr_rvalid_i);
            if (w_drop) begin
                r_discard <= r_discard - CW'(1);
            end
            if (w_accept) begin
                r_resp_pc <= r_resp_pc + XLEN'(4);
            end
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);

            // Output advance: FIFO head first, then bypassed response, else bubble.
            if (!cu_stall_f_i) begin
                if (w_pop) begin
                    r_f_instr   <= r_fifo_instr[r_rptr];
                    r_f_pc      <= r_fifo_pc[r_rptr];
                    r_f_next_pc <= r_fifo_pc[r_rptr] + XLEN'(4);
                    r_f_valid   <= 1'b1;
                end else if (w_bypass) begin
                    r_f_instr   <= w_rinstr;
                    r_f_pc      <= r_resp_pc;
                    r_f_next_pc <= r_resp_pc + XLEN'(4);
                    r_f_valid   <= 1'b1;
                end else begin
                    r_f_instr   <= L_NOP;
                    r_f_valid   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_miriscv_prefetch_stage.sv
// Bench for miriscv_prefetch_stage: directed scenarios plus randomized traffic checked against
// an instruction-stream model built from epochs, an in-flight memory queue and a pending queue.
module tb_miriscv_prefetch_stage;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_OUT = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] boot_addr_i;
    logic        instr_req_o;
    logic        instr_gnt_i;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic [31:0] cu_pc_bra_i;
    logic        cu_kill_f_i;
    logic        cu_boot_addr_load_en_i;
    logic        cu_stall_f_i;
    logic [31:0] f_instr_o;
    logic [31:0] f_current_pc_o;
    logic [31:0] f_next_pc_o;
    logic        f_valid_o;

    always #5 clk_i = ~clk_i;

    miriscv_prefetch_stage #(
        .XLEN(32), .ILEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .boot_addr_i            (boot_addr_i),
        .instr_req_o            (instr_req_o),
        .instr_gnt_i            (instr_gnt_i),
        .instr_addr_o           (instr_addr_o),
        .instr_rvalid_i         (instr_rvalid_i),
        .instr_rdata_i          (instr_rdata_i),
        .cu_pc_bra_i            (cu_pc_bra_i),
        .cu_kill_f_i            (cu_kill_f_i),
        .cu_boot_addr_load_en_i (cu_boot_addr_load_en_i),
        .cu_stall_f_i           (cu_stall_f_i),
        .f_instr_o              (f_instr_o),
        .f_current_pc_o         (f_current_pc_o),
        .f_next_pc_o            (f_next_pc_o),
        .f_valid_o              (f_valid_o)
    );

    typedef struct { logic [31:0] addr; int epoch; int cyc; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    mreq_t       memq[$];
    ent_t        expq[$];
    int          epoch;
    int          cyc;
    logic [31:0] exp_issue;
    logic [31:0] m_instr, m_pc, m_npc;
    logic        m_valid;
    int          n_assert;
    int          n_fail;
    int          vcount;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_out();
        chk("f_valid", 32'(f_valid_o), 32'(m_valid));
        chk("f_instr", f_instr_o, m_instr);
        chk("f_current_pc", f_current_pc_o, m_pc);
        chk("f_next_pc", f_next_pc_o, m_npc);
    endtask

    // One clock: drive inputs, predict request/issue/response effects, then check outputs.
    task automatic cycle(input bit stall, input bit kill, input bit boot, input bit gnt,
                         input int rv_pct);
        bit          rv, redirect, exp_req;
        int          live;
        logic [31:0] target;
        mreq_t       m;
        ent_t        e;
        rv = (memq.size() > 0) && (memq[0].cyc < cyc) && (int'($urandom_range(99)) < rv_pct);
        cu_stall_f_i           = stall;
        cu_kill_f_i            = kill;
        cu_boot_addr_load_en_i = boot;
        instr_gnt_i            = gnt;
        instr_rvalid_i         = rv;
        instr_rdata_i          = rv ? mem_word(memq[0].addr) : $urandom();
        #1;
        redirect = kill | boot;
        target   = kill ? cu_pc_bra_i : boot_addr_i;
        live = 0;
        foreach (memq[i]) if (memq[i].epoch == epoch) live++;
        exp_req = !redirect && (live + expq.size() < DEPTH) && (memq.size() < MAX_OUT);
        chk("instr_req", 32'(instr_req_o), 32'(exp_req));
        if (exp_req && gnt) chk("instr_addr", instr_addr_o, exp_issue);
        if (rv) begin
            m = memq.pop_front();
            if (m.epoch == epoch && !redirect) begin
                e.pc = m.addr; e.instr = mem_word(m.addr);
                expq.push_back(e);
            end
        end
        if (exp_req && gnt) begin
            m.addr = exp_issue; m.epoch = epoch; m.cyc = cyc;
            memq.push_back(m);
            exp_issue = exp_issue + 32'd4;
        end
        if (redirect) begin
            epoch++;
            expq.delete();
            exp_issue = target;
            m_instr = 32'h13; m_pc = '0; m_npc = '0; m_valid = 1'b0;
        end else if (!stall) begin
            if (expq.size() > 0) begin
                e = expq.pop_front();
                m_instr = e.instr; m_pc = e.pc; m_npc = e.pc + 32'd4; m_valid = 1'b1;
            end else begin
                m_instr = 32'h13; m_valid = 1'b0;
            end
        end
        @(posedge clk_i);
        #1;
        cyc++;
        chk_out();
        if (f_valid_o) vcount++;
    endtask

    task automatic do_reset(input logic [31:0] boot);
        rst_i = 1'b1; boot_addr_i = boot; instr_rvalid_i = 1'b0; instr_gnt_i = 1'b1;
        cu_kill_f_i = 1'b0; cu_boot_addr_load_en_i = 1'b0; cu_stall_f_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("req_in_reset", 32'(instr_req_o), 32'd0);
            @(posedge clk_i);
            #1;
            cyc++;
        end
        memq.delete(); expq.delete(); epoch++;
        exp_issue = boot;
        m_instr = 32'h13; m_pc = '0; m_npc = '0; m_valid = 1'b0;
        chk_out();
        rst_i = 1'b0;
    endtask

    initial begin
        n_assert = 0; n_fail = 0; epoch = 0; cyc = 0; vcount = 0;
        cu_pc_bra_i = '0; instr_rdata_i = '0;
        @(posedge clk_i);
        #1;

        // Reset, then zero-wait memory: first valid two cycles after first grant, then 1/cycle.
        do_reset(32'h8000_0000);
        cycle(0, 0, 0, 1, 100);
        chk("lat_first_cycle", 32'(f_valid_o), 32'd0);
        cycle(0, 0, 0, 1, 100);
        chk("lat_second_cycle", 32'(f_valid_o), 32'd1);
        chk("first_pc", f_current_pc_o, 32'h8000_0000);
        vcount = 0;
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 100);
        chk("throughput", 32'(vcount), 32'd10);

        // Long stall fills FIFO; request must drop, then entries drain back-to-back.
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 1, 100);
        chk("req_dropped_in_stall", 32'(instr_req_o), 32'd0);
        vcount = 0;
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 100);
        chk("drain_back_to_back", 32'(vcount), 32'd4);

        // Kill to 0x100 with two requests in flight.
        for (int i = 0; i < 10 && memq.size() < 2; i++) cycle(0, 0, 0, 1, 0);
        chk("inflight_before_kill", 32'(memq.size()), 32'd2);
        cu_pc_bra_i = 32'h100;
        cycle(0, 1, 0, 1, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 100);

        // Kill coinciding with a response while stalled.
        for (int i = 0; i < 10 && memq.size() < 2; i++) cycle(0, 0, 0, 1, 0);
        cu_pc_bra_i = 32'h400;
        cycle(1, 1, 0, 1, 100);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 100);

        // Address wrap at the top of the address space.
        cu_pc_bra_i = 32'hFFFF_FFF8;
        cycle(0, 1, 0, 1, 100);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 100);

        // Kill and boot together go to cu_pc_bra_i; boot alone goes to boot_addr_i.
        cu_pc_bra_i = 32'h2000; boot_addr_i = 32'h0000_3000;
        cycle(0, 1, 1, 1, 100);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 100);
        cycle(0, 0, 1, 1, 100);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 100);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cu_pc_bra_i = {$urandom()} & 32'hFFFF_FFFC;
            boot_addr_i = {$urandom()} & 32'hFFFF_FFFC;
            cycle($urandom_range(99) < 30, $urandom_range(99) < 2, $urandom_range(99) < 1,
                  $urandom_range(99) < 70, 60);
        end

        // Drain with no new requests; output must end idle.
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 100);
        chk("idle_at_end", 32'(f_valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
